// File: rtl/calc3_pkg.sv
// Shared calc3 definitions: default field widths and the buffered request entry.
package calc3_pkg;

    localparam int unsigned CALC3_REG_W  = 4;
    localparam int unsigned CALC3_TAG_W  = 2;
    localparam int unsigned CALC3_DATA_W = 32;

    typedef struct packed {
        logic [CALC3_REG_W-1:0]  cmd;
        logic [CALC3_REG_W-1:0]  d1;
        logic [CALC3_REG_W-1:0]  d2;
        logic [CALC3_REG_W-1:0]  r1;
        logic [CALC3_TAG_W-1:0]  tag;
        logic [CALC3_DATA_W-1:0] data;
    } req_entry_t;

endpackage

// File: rtl/hold_queue_ctrl.sv
// Read/write pointers, fill count and sticky overflow for the hold queue.
// Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
module hold_queue_ctrl #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_c,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic             pop_c;
    logic             drop_c;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees the slot in the same edge, so a push at full is accepted alongside it
    always_comb begin
        pop_c     = 1'b0;
        push_c    = 1'b0;
        drop_c    = 1'b0;
        count_nxt = count;
        pop_c     = pop_req && (count != '0);
        push_c    = push_req && ((count != CNT_W'(DEPTH)) || pop_c);
        drop_c    = push_req && !push_c;
        case ({push_c, pop_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            if (drop_c) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/hold_queue.sv
// Request hold queue: buffers calc3 requests in FIFO order ahead of the priority logic.
// State advances on the falling edge of c_clk; head outputs are combinational from storage.
module hold_queue
    import calc3_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = CALC3_DATA_W,
    parameter  int unsigned REG_W  = CALC3_REG_W,
    parameter  int unsigned TAG_W  = CALC3_TAG_W,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [REG_W-1:0]  req_cmd_in,
    input  logic [REG_W-1:0]  req_d1,
    input  logic [REG_W-1:0]  req_d2,
    input  logic [REG_W-1:0]  req_r1,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
    input  logic              prio_ack,
    output logic              req_ready,
    output logic [REG_W-1:0]  hold_prio_req,
    output logic [REG_W-1:0]  hold_d1,
    output logic [REG_W-1:0]  hold_d2,
    output logic [REG_W-1:0]  hold_r1,
    output logic [TAG_W-1:0]  hold_prio_tag,
    output logic [DATA_W-1:0] hold_data,
    output logic [CNT_W-1:0]  hold_count,
    output logic              hold_overflow
);

    // Entries are stored in the shared struct, so the fields must fit it
    if (REG_W > CALC3_REG_W || TAG_W > CALC3_TAG_W || DATA_W > CALC3_DATA_W || DEPTH < 2)
    begin : g_param_check
        $error("hold_queue: unsupported DEPTH or field width");
    end

    logic             push_c;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    req_entry_t       wr_entry;
    req_entry_t       head;
    req_entry_t       mem [DEPTH];

    hold_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (c_clk),
        .rst_n    (reset_n),
        .push_req (req_cmd_in != '0),
        .pop_req  (prio_ack),
        .push_c   (push_c),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (hold_count),
        .overflow (hold_overflow)
    );

    always_comb begin
        wr_entry      = '0;
        wr_entry.cmd  = CALC3_REG_W'(req_cmd_in);
        wr_entry.d1   = CALC3_REG_W'(req_d1);
        wr_entry.d2   = CALC3_REG_W'(req_d2);
        wr_entry.r1   = CALC3_REG_W'(req_r1);
        wr_entry.tag  = CALC3_TAG_W'(req_tag);
        wr_entry.data = CALC3_DATA_W'(req_data);
    end

    // Storage carries no reset; stale slots are hidden by the empty gating below
    always_ff @(negedge c_clk) begin
        if (push_c) mem[wr_ptr] <= wr_entry;
    end

    assign head      = mem[rd_ptr];
    assign req_ready = (hold_count != CNT_W'(DEPTH));

    always_comb begin
        hold_prio_req = '0;
        hold_d1       = '0;
        hold_d2       = '0;
        hold_r1       = '0;
        hold_prio_tag = '0;
        hold_data     = '0;
        if (hold_count != '0) begin
            hold_prio_req = REG_W'(head.cmd);
            hold_d1       = REG_W'(head.d1);
            hold_d2       = REG_W'(head.d2);
            hold_r1       = REG_W'(head.r1);
            hold_prio_tag = TAG_W'(head.tag);
            hold_data     = DATA_W'(head.data);
        end
    end

endmodule
